wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter CNT_W, default 64, width of the committed-write counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 WB_PCplus4  input  32  PC+4 of the instruction in writeback.
REQ-005 WB_BranchAddr  input  32  branch/jump target (AUIPC-style result).
REQ-006 WB_immediate  input  32  immediate (LUI result).
REQ-007 WB_cntl_RegWrite  input  1  writeback enable.
REQ-008 WB_sel_MemToReg  input  3  source select: 000 ALUResult, 001 load data, 010 immediate, 011 BranchAddr, 100 PCplus4.
REQ-009 WB_funct  input  3  load width/sign code (funct3).
REQ-010 WB_ReadMemData  input  32  raw aligned data-memory word.
REQ-011 WB_ALUResult  input  32  ALU result; bits [1:0] give the load byte offset.
REQ-012 WB_WriteRegNum  input  5  destination register rd.
REQ-013 ID_rs1, ID_rs2  input  5 each  decode-stage read addresses.
REQ-014 ID_rdata1, ID_rdata2  output  32 each  read data for rs1/rs2.
REQ-015 WB_WriteData  output  32  selected writeback value, combinational, for forwarding.
REQ-016 wb_count  output  CNT_W  number of committed register writes.

Function
REQ-017 Load extraction: byte = word[8*off +: 8], half = word[16*ALUResult[1] +: 16], where off = ALUResult[1:0].
REQ-018 Load extraction by WB_funct:
- 000 sign-extended byte
- 001 sign-extended half
- 010 full word
- 100 zero-extended byte
- 101 zero-extended half
- 011, 110, 111 full word
REQ-019 WB_WriteData is selected per REQ-008; sel 101/110/111 produce 32'h0.
REQ-020 A commit occurs when WB_cntl_RegWrite=1 and WB_WriteRegNum!=0.
REQ-021 On a commit, regs[WB_WriteRegNum] takes WB_WriteData at the rising edge of clk.
REQ-022 Writes to x0 are discarded.
REQ-023 Reads of x0 return 0 regardless of bypass.
REQ-024 Reads are combinational.
REQ-025 Write-through bypass: if ID_rsN equals WB_WriteRegNum and a commit is pending this cycle, ID_rdataN = WB_WriteData in the same cycle; otherwise ID_rdataN = regs[ID_rsN].
REQ-026 Both read ports may bypass simultaneously when rs1 = rs2 = rd.
REQ-027 wb_count increments by 1 on each commit edge and holds otherwise.
REQ-028 wb_count wraps from all-ones to 0 without flag.
REQ-029 Write latency: a value committed at edge N is visible from the array from edge N onward; it is visible via bypass in the cycle before edge N.
REQ-030 Storage is 31 × 32-bit registers (x1–x31); x0 is not stored.

Reset
REQ-031 While reset=1, all of x1–x31 are cleared to 0 and wb_count is 0, immediately and independent of clk.
REQ-032 While reset=1, no commit takes effect, and the bypass path is suppressed so that ID_rdata1/2 read 0.
REQ-033 Reset asserted mid-operation discards any write whose edge coincides with reset; on release, the first rising edge with reset=0 resumes normal commits.
REQ-034 WB_WriteData remains purely combinational during reset.

Verification
REQ-035 Reset, then sel=000, ALUResult=32'h1234_5678, RegWrite=1, rd=5, one edge -> reading rs1=5 returns 32'h1234_5678; wb_count=1.
REQ-036 sel=001, ReadMemData=32'h80FF_7F01, ALUResult[1:0]=3: funct 000 -> 32'hFFFF_FF80; funct 100 -> 32'h0000_0080; ALUResult[1:0]=2 with funct 001 -> 32'hFFFF_80FF.
REQ-037 RegWrite=1, rd=0, sel=100, PCplus4=32'h40 -> x0 reads 0 and wb_count is unchanged.
REQ-038 rd=7, sel=010, immediate=32'hABCD_E000, rs1=rs2=7 before the edge -> both outputs return 32'hABCD_E000 combinationally; after the edge, with RegWrite=0, both still return that value.
REQ-039 Preload wb_count to all-ones (CNT_W=4, 15 commits), then one more commit -> wb_count=0; assert reset mid-cycle during a commit to x9 -> x9 reads 0 and wb_count=0 immediately.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Writeback/decode bus for the integer register file.
interface wb_regfile_if #(
  parameter int unsigned CNT_W = 64
);
  logic [31:0]      WB_PCplus4;
  logic [31:0]      WB_BranchAddr;
  logic [31:0]      WB_immediate;
  logic             WB_cntl_RegWrite;
  logic [2:0]       WB_sel_MemToReg;
  logic [2:0]       WB_funct;
  logic [31:0]      WB_ReadMemData;
  logic [31:0]      WB_ALUResult;
  logic [4:0]       WB_WriteRegNum;
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic [31:0]      ID_rdata1;
  logic [31:0]      ID_rdata2;
  logic [31:0]      WB_WriteData;
  logic [CNT_W-1:0] wb_count;

  modport master (
    output WB_PCplus4, WB_BranchAddr, WB_immediate, WB_cntl_RegWrite,
           WB_sel_MemToReg, WB_funct, WB_ReadMemData, WB_ALUResult,
           WB_WriteRegNum, ID_rs1, ID_rs2,
    input  ID_rdata1, ID_rdata2, WB_WriteData, wb_count
  );

  modport slave (
    input  WB_PCplus4, WB_BranchAddr, WB_immediate, WB_cntl_RegWrite,
           WB_sel_MemToReg, WB_funct, WB_ReadMemData, WB_ALUResult,
           WB_WriteRegNum, ID_rs1, ID_rs2,
    output ID_rdata1, ID_rdata2, WB_WriteData, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// RV32 register file with writeback source mux, load extraction,
// write-through bypass to the decode read ports and a commit counter.
module wb_regfile #(
  parameter int unsigned CNT_W = 64
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  logic [XLEN-1:0]  r_regs [1:NREG-1];
  logic [CNT_W-1:0] r_count;

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_load;
  logic [XLEN-1:0]  w_wdata;
  logic             w_commit;

  assign w_byte = bus.WB_ReadMemData[{bus.WB_ALUResult[1:0], 3'b000} +: 8];
  assign w_half = bus.WB_ReadMemData[{bus.WB_ALUResult[1], 4'b0000} +: 16];

  always_comb begin
    w_load = bus.WB_ReadMemData;
    case (bus.WB_funct)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = bus.WB_ReadMemData;
    endcase
  end

  always_comb begin
    w_wdata = '0;
    case (bus.WB_sel_MemToReg)
      3'b000:  w_wdata = bus.WB_ALUResult;
      3'b001:  w_wdata = w_load;
      3'b010:  w_wdata = bus.WB_immediate;
      3'b011:  w_wdata = bus.WB_BranchAddr;
      3'b100:  w_wdata = bus.WB_PCplus4;
      default: w_wdata = '0;
    endcase
  end

  assign bus.WB_WriteData = w_wdata;

  // Reset masks the commit so neither the array nor the bypass sees it.
  assign w_commit = bus.WB_cntl_RegWrite && (bus.WB_WriteRegNum != 5'd0) && !reset;

  always_comb begin
    bus.ID_rdata1 = '0;
    if (reset || bus.ID_rs1 == 5'd0)
      bus.ID_rdata1 = '0;
    else if (w_commit && bus.ID_rs1 == bus.WB_WriteRegNum)
      bus.ID_rdata1 = w_wdata;
    else
      bus.ID_rdata1 = r_regs[bus.ID_rs1];
  end

  always_comb begin
    bus.ID_rdata2 = '0;
    if (reset || bus.ID_rs2 == 5'd0)
      bus.ID_rdata2 = '0;
    else if (w_commit && bus.ID_rs2 == bus.WB_WriteRegNum)
      bus.ID_rdata2 = w_wdata;
    else
      bus.ID_rdata2 = r_regs[bus.ID_rs2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < int'(NREG); i++) r_regs[i] <= '0;
      r_count <= '0;
    end else if (w_commit) begin
      r_regs[bus.WB_WriteRegNum] <= w_wdata;
      r_count                    <= r_count + CNT_W'(1);
    end
  end

  assign bus.wb_count = r_count;
endmodule
